board_port_arbiter: RTL and testbench

BOARD_PORT_ARBITER -- requirements
Module: board_port_arbiter

---
 rtl/board_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_board_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_port_arbiter.sv
// Shared memory-port arbiter: a pipelined display read stream against NCH round-robin
// write channels, with a starvation override that forces a pending write through.
module board_port_arbiter #(
    parameter int NCH       = 4,
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int EDGE_MODE = 1,
    parameter int MAX_WAIT  = 15
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iRD_REQ,
    input  logic [AW-1:0]     iRD_ADDR,
    output logic [DW-1:0]     oRD_DATA,
    output logic              oRD_VALID,
    output logic              oRD_DROP,
    input  logic [NCH-1:0]    iWR_REQ,
    input  logic [NCH*AW-1:0] iWR_ADDR,
    input  logic [NCH*DW-1:0] iWR_DATA,
    output logic [NCH-1:0]    oWR_ACK,
    output logic [AW-1:0]     oMEM_ADDR,
    output logic [DW-1:0]     oMEM_DATA,
    output logic              oMEM_WE,
    input  logic [DW-1:0]     iMEM_Q
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE
    } slot_e;

    logic [NCH-1:0] r_req_prev;
    logic [NCH-1:0] r_pend;
    logic [AW-1:0]  r_hold_addr [NCH];
    logic [DW-1:0]  r_hold_data [NCH];
    logic [PW-1:0]  r_rr_ptr;
    logic [7:0]     r_wait_cnt;
    logic           r_rd_p1;
    logic           r_rd_p2;

    logic [AW-1:0]  w_in_addr [NCH];
    logic [DW-1:0]  w_in_data [NCH];
    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_cap;
    logic [NCH-1:0] w_clear;
    logic [NCH-1:0] w_pend_nxt;
    logic           w_any_pend;
    logic           w_force;
    slot_e          w_slot;
    logic [PW-1:0]  w_cand;
    logic [PW-1:0]  w_grant_idx;
    logic           w_grant_found;
    logic [PW-1:0]  w_rr_nxt;
    logic [AW-1:0]  w_grant_addr;
    logic [DW-1:0]  w_grant_data;
    logic [7:0]     w_wait_nxt;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_in_addr[i] = iWR_ADDR[i*AW +: AW];
            w_in_data[i] = iWR_DATA[i*DW +: DW];
        end
    end

    // NOTE: deliberately no reset here, so a request held high through reset is sampled
    // as "previous high" and does not count as a fresh edge after release.
    always_ff @(posedge iCLK) begin
        r_req_prev <= iWR_REQ;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_pend = (EDGE_MODE != 0) ? r_pend : iWR_REQ;
        w_any_pend = |w_pend;
        w_force = w_any_pend && (r_wait_cnt >= 8'(MAX_WAIT));
        w_slot = SLOT_IDLE;
        if (w_force || (w_any_pend && !iRD_REQ)) begin
            w_slot = SLOT_WRITE;
        end else if (iRD_REQ) begin
            w_slot = SLOT_READ;
        end
    end

    // Round-robin search starting at the pointer; first pending channel wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx = r_rr_ptr;
        w_cand = r_rr_ptr;
        for (int k = 0; k < NCH; k++) begin
            w_cand = PW'((int'(r_rr_ptr) + k) % NCH);
            if (!w_grant_found && w_pend[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        w_rr_nxt = (w_grant_idx == PW'(NCH - 1)) ? '0 : w_grant_idx + PW'(1);
        w_clear = '0;
        if (w_slot == SLOT_WRITE) begin
            w_clear[w_grant_idx] = 1'b1;
        end
        if (EDGE_MODE != 0) begin
            w_grant_addr = r_hold_addr[w_grant_idx];
            w_grant_data = r_hold_data[w_grant_idx];
        end else begin
            w_grant_addr = w_in_addr[w_grant_idx];
            w_grant_data = w_in_data[w_grant_idx];
        end
    end

    // A new edge is accepted when idle, or in the very cycle the old request is granted.
    always_comb begin
        w_rise = iWR_REQ & ~r_req_prev;
        w_cap = '0;
        w_pend_nxt = '0;
        if (EDGE_MODE != 0) begin
            w_cap = w_rise & (~r_pend | w_clear);
            w_pend_nxt = w_cap | (r_pend & ~w_clear);
        end
        if ((w_slot == SLOT_WRITE) || !w_any_pend) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt != 8'hFF) begin
            w_wait_nxt = r_wait_cnt + 8'd1;
        end else begin
            w_wait_nxt = r_wait_cnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_pend <= '0;
            r_rr_ptr <= '0;
            r_wait_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_hold_addr[i] <= '0;
                r_hold_data[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_slot == SLOT_WRITE) begin
                r_rr_ptr <= w_rr_nxt;
            end
            for (int i = 0; i < NCH; i++) begin
                if (w_cap[i]) begin
                    r_hold_addr[i] <= w_in_addr[i];
                    r_hold_data[i] <= w_in_data[i];
                end
            end
        end
    end

    // Memory port and read return pipeline: slot t -> port t+1 -> Q t+2 -> data t+3.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oMEM_WE <= 1'b0;
            oMEM_ADDR <= '0;
            oMEM_DATA <= '0;
            oWR_ACK <= '0;
            oRD_DROP <= 1'b0;
            oRD_VALID <= 1'b0;
            oRD_DATA <= '0;
            r_rd_p1 <= 1'b0;
            r_rd_p2 <= 1'b0;
        end else begin
            oMEM_WE <= 1'b0;
            oWR_ACK <= '0;
            oRD_DROP <= w_force && iRD_REQ;
            r_rd_p1 <= (w_slot == SLOT_READ);
            r_rd_p2 <= r_rd_p1;
            oRD_VALID <= r_rd_p2;
            if (r_rd_p2) begin
                oRD_DATA <= iMEM_Q;
            end
            case (w_slot)
                SLOT_WRITE: begin
                    oMEM_WE <= 1'b1;
                    oMEM_ADDR <= w_grant_addr;
                    oMEM_DATA <= w_grant_data;
                    oWR_ACK <= w_clear;
                end
                SLOT_READ: begin
                    oMEM_ADDR <= iRD_ADDR;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed bench for board_port_arbiter: an edge-mode instance with a registered
// memory model, plus a level-mode instance for held-request behaviour.
module tb_board_port_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 12;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_drop;
    logic [NCH-1:0]    wr_req;
    logic [NCH*AW-1:0] wr_addr;
    logic [NCH*DW-1:0] wr_data;
    logic [NCH-1:0]    wr_ack;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data;
    logic              mem_we;
    logic [DW-1:0]     mem_q;

    logic [NCH-1:0]    lv_wr_req;
    logic [NCH*AW-1:0] lv_wr_addr;
    logic [NCH*DW-1:0] lv_wr_data;
    logic [NCH-1:0]    lv_wr_ack;
    logic [DW-1:0]     lv_rd_data;
    logic              lv_rd_valid;
    logic              lv_rd_drop;
    logic [AW-1:0]     lv_mem_addr;
    logic [DW-1:0]     lv_mem_data;
    logic              lv_mem_we;

    int total = 0;
    int bad = 0;

    board_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .EDGE_MODE(1), .MAX_WAIT(15)) dut (
        .iCLK(clk), .iRST_n(rst_n),
        .iRD_REQ(rd_req), .iRD_ADDR(rd_addr),
        .oRD_DATA(rd_data), .oRD_VALID(rd_valid), .oRD_DROP(rd_drop),
        .iWR_REQ(wr_req), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data), .oWR_ACK(wr_ack),
        .oMEM_ADDR(mem_addr), .oMEM_DATA(mem_data), .oMEM_WE(mem_we), .iMEM_Q(mem_q)
    );

    board_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .EDGE_MODE(0), .MAX_WAIT(15)) dut_lvl (
        .iCLK(clk), .iRST_n(rst_n),
        .iRD_REQ(1'b0), .iRD_ADDR('0),
        .oRD_DATA(lv_rd_data), .oRD_VALID(lv_rd_valid), .oRD_DROP(lv_rd_drop),
        .iWR_REQ(lv_wr_req), .iWR_ADDR(lv_wr_addr), .iWR_DATA(lv_wr_data), .oWR_ACK(lv_wr_ack),
        .oMEM_ADDR(lv_mem_addr), .oMEM_DATA(lv_mem_data), .oMEM_WE(lv_mem_we), .iMEM_Q('0)
    );

    // Memory returns data one cycle after the address is on the port.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return (a == 12'd8) ? 32'h0000_1234 : (32'hA5A5_0000 | {20'h0, a});
    endfunction

    always @(posedge clk) mem_q <= mem_f(mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[ch*AW +: AW] = a;
        wr_data[ch*DW +: DW] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_req = 1'b0;
        rd_addr = '0;
        wr_req = '0;
        wr_addr = '0;
        wr_data = '0;
        lv_wr_req = '0;
        lv_wr_addr = '0;
        lv_wr_data = '0;
        tick();
        tick();
        check("rst_we", mem_we, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_drop", rd_drop, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_mdata", mem_data, 0);
        check("rst_rdata", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Level mode: request held three cycles, data sampled at each grant.
        lv_wr_addr[1*AW +: AW] = 12'h041;
        lv_wr_data[1*DW +: DW] = 32'h61;
        lv_wr_req = 4'b0010;
        tick();
        check("lvl_ack1", lv_wr_ack, 4'b0010);
        check("lvl_data1", lv_mem_data, 32'h61);
        lv_wr_data[1*DW +: DW] = 32'h62;
        tick();
        check("lvl_ack2", lv_wr_ack, 4'b0010);
        check("lvl_data2", lv_mem_data, 32'h62);
        lv_wr_data[1*DW +: DW] = 32'h63;
        tick();
        check("lvl_ack3", lv_wr_ack, 4'b0010);
        check("lvl_data3", lv_mem_data, 32'h63);
        lv_wr_req = '0;
        tick();
        check("lvl_ack_end", lv_wr_ack, 0);
        check("lvl_we_end", lv_mem_we, 0);

        // Single edge write on channel 2.
        set_ch(2, 12'd36, 32'h49);
        wr_req = 4'b0100;
        tick();
        wr_req = '0;
        tick();
        check("wr1_we", mem_we, 1);
        check("wr1_addr", mem_addr, 36);
        check("wr1_data", mem_data, 32'h49);
        check("wr1_ack", wr_ack, 4'b0100);
        tick();
        check("wr1_we_off", mem_we, 0);
        check("wr1_ack_off", wr_ack, 0);
        check("idle_addr_hold", mem_addr, 36);

        // Back-to-back reads, latency 3.
        rd_req = 1'b1;
        rd_addr = 12'd8;
        tick();
        check("rd_port_addr", mem_addr, 8);
        check("rd_port_we", mem_we, 0);
        rd_addr = 12'd9;
        tick();
        check("rd_not_early", rd_valid, 0);
        rd_addr = 12'd10;
        tick();
        check("rd0_valid", rd_valid, 1);
        check("rd0_data", rd_data, 32'h1234);
        rd_req = 1'b0;
        tick();
        check("rd1_valid", rd_valid, 1);
        check("rd1_data", rd_data, 32'hA5A5_0009);
        tick();
        check("rd2_valid", rd_valid, 1);
        check("rd2_data", rd_data, 32'hA5A5_000A);
        tick();
        check("rd_done_valid", rd_valid, 0);
        check("rd_done_hold", rd_data, 32'hA5A5_000A);

        // Re-edge while pending is ignored: one ack with first-captured data.
        rd_req = 1'b1;
        set_ch(1, 12'h031, 32'h51);
        wr_req = 4'b0010;
        tick();
        wr_req = '0;
        tick();
        set_ch(1, 12'h032, 32'h52);
        wr_req = 4'b0010;
        tick();
        rd_req = 1'b0;
        wr_req = '0;
        tick();
        check("reedge_ack", wr_ack, 4'b0010);
        check("reedge_data", mem_data, 32'h51);
        check("reedge_addr", mem_addr, 12'h031);
        tick();
        check("reedge_single", wr_ack, 0);

        // Starvation: reads held, channel 0 forced through after MAX_WAIT cycles.
        rd_addr = 12'd20;
        rd_req = 1'b1;
        set_ch(0, 12'd7, 32'h77);
        wr_req = 4'b0001;
        tick();
        wr_req = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("starve_noack", wr_ack, 0);
        end
        check("starve_noforce_we", mem_we, 0);
        tick();
        check("starve_ack", wr_ack, 4'b0001);
        check("starve_drop", rd_drop, 1);
        check("starve_we", mem_we, 1);
        check("starve_addr", mem_addr, 7);
        check("starve_data", mem_data, 32'h77);
        tick();
        check("resume_we", mem_we, 0);
        check("resume_drop", rd_drop, 0);
        check("resume_addr", mem_addr, 20);
        check("resume_valid", rd_valid, 1);
        tick();
        check("dropped_no_valid", rd_valid, 0);
        tick();
        check("after_drop_valid", rd_valid, 1);
        check("after_drop_data", rd_data, 32'hA5A5_0014);
        rd_req = 1'b0;
        tick();
        tick();
        tick();

        // Edge in the cycle a channel's pend clears re-arms it with new data.
        set_ch(1, 12'h081, 32'h810);
        set_ch(2, 12'h082, 32'h200);
        wr_req = 4'b0110;
        tick();
        wr_req = '0;
        tick();
        check("rearm_ack1", wr_ack, 4'b0010);
        check("rearm_addr1", mem_addr, 12'h081);
        set_ch(2, 12'h092, 32'h222);
        wr_req = 4'b0100;
        tick();
        check("rearm_ack2", wr_ack, 4'b0100);
        check("rearm_data2", mem_data, 32'h200);
        wr_req = '0;
        tick();
        check("rearm_ack3", wr_ack, 4'b0100);
        check("rearm_data3", mem_data, 32'h222);
        check("rearm_addr3", mem_addr, 12'h092);
        tick();
        check("rearm_end", wr_ack, 0);

        // Reset during a write: outputs clear at once, nothing replayed afterwards.
        set_ch(0, 12'h010, 32'h100);
        set_ch(1, 12'h011, 32'h101);
        wr_req = 4'b0011;
        tick();
        wr_req = '0;
        tick();
        check("midwr_we", mem_we, 1);
        check("midwr_ack", wr_ack, 4'b0001);
        rst_n = 1'b0;
        wr_req = 4'b1000;
        #1;
        check("async_we", mem_we, 0);
        check("async_ack", wr_ack, 0);
        check("async_addr", mem_addr, 0);
        check("async_data", mem_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_noack", wr_ack, 0);
            check("post_rst_nowe", mem_we, 0);
        end
        wr_req = '0;
        tick();

        // Round-robin from rr_ptr=0: 0,1,3 then 0,1.
        set_ch(0, 12'h0A0, 32'hC0);
        set_ch(1, 12'h0A1, 32'hC1);
        set_ch(3, 12'h0A3, 32'hC3);
        wr_req = 4'b1011;
        tick();
        wr_req = '0;
        tick();
        check("rr_ack0", wr_ack, 4'b0001);
        check("rr_addr0", mem_addr, 12'h0A0);
        tick();
        check("rr_ack1", wr_ack, 4'b0010);
        check("rr_data1", mem_data, 32'hC1);
        tick();
        check("rr_ack3", wr_ack, 4'b1000);
        check("rr_data3", mem_data, 32'hC3);
        wr_req = 4'b0011;
        tick();
        wr_req = '0;
        tick();
        check("rr2_ack0", wr_ack, 4'b0001);
        tick();
        check("rr2_ack1", wr_ack, 4'b0010);
        tick();
        check("rr2_end_ack", wr_ack, 0);
        check("rr2_end_we", mem_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
